// File: rtl/mux12_scheduler.sv
// Round-robin 12:1 word scheduler: grants one requester at a time for up to MAX_BURST words.
// Latency: req to grant 1 cycle, one IDLE cycle between grants; out_data/out_valid/ack are combinational.
// Backpressure: out_ready low holds word and burst count; a dropped req[sel] aborts the grant without a transfer.
module mux12_scheduler #(
    parameter int N_REQ     = 12,
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [3:0]         sel,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [3:0] LAST_IDX  = 4'(N_REQ - 1);

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] burst_cnt;
    logic [3:0] pick_idx;
    logic       pick_vld;
    logic [4:0] scan_idx;
    logic [3:0] sel_next;
    logic       xfer;
    logic       leave_grant;

    // First set req bit at or above ptr, wrapping past the top index.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = 5'(ptr) + 5'(k);
            if (scan_idx >= 5'(N_REQ)) begin
                scan_idx = scan_idx - 5'(N_REQ);
            end
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx[3:0];
            end
        end
    end

    // 12:1 W-bit word mux driven by the registered select.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == 4'(k)) begin
                out_data = data[k*W +: W];
            end
        end
    end

    assign sel_next    = (sel == LAST_IDX) ? 4'd0 : sel + 4'd1;
    assign out_valid   = (state == GRANT) && req[sel];
    assign xfer        = out_valid && out_ready;
    assign ack         = xfer ? grant : '0;
    assign leave_grant = !req[sel] || (xfer && (burst_cnt == LAST_BEAT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= GRANT;
                        sel       <= pick_idx;
                        grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (leave_grant) begin
                        // Last winner drops to lowest priority for the next scan.
                        state     <= IDLE;
                        ptr       <= sel_next;
                        sel       <= '0;
                        grant     <= '0;
                        burst_cnt <= '0;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux12_scheduler.sv
// Bench for mux12_scheduler: two instances (MAX_BURST 4 and 1) share stimulus and are
// compared against a per-instance transaction-level round-robin model.
module tb_mux12_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] req;
    logic [47:0] data;
    logic        out_ready;

    logic        d_vld   [2];
    logic [3:0]  d_dat   [2];
    logic [3:0]  d_sel   [2];
    logic [11:0] d_grant [2];
    logic [11:0] d_ack   [2];

    int checks   = 0;
    int failures = 0;

    bit m_in_g  [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_beats [2];
    int maxb    [2] = '{4, 1};

    always #5 clk = ~clk;

    mux12_scheduler #(.N_REQ(12), .W(4), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .out_ready(out_ready),
        .out_valid(d_vld[0]), .out_data(d_dat[0]), .sel(d_sel[0]),
        .grant(d_grant[0]), .ack(d_ack[0])
    );

    mux12_scheduler #(.N_REQ(12), .W(4), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .data(data), .out_ready(out_ready),
        .out_valid(d_vld[1]), .out_data(d_dat[1]), .sel(d_sel[1]),
        .grant(d_grant[1]), .ack(d_ack[1])
    );

    // Reference model: who owns the output, how many words it has moved, who is next in line.
    function automatic logic [11:0] e_grant(int i);
        logic [11:0] one;
        one = 12'h001;
        return m_in_g[i] ? (one << m_owner[i]) : 12'h000;
    endfunction

    function automatic logic [3:0] e_sel(int i);
        return m_in_g[i] ? 4'(m_owner[i]) : 4'h0;
    endfunction

    function automatic logic e_vld(int i);
        return m_in_g[i] && req[m_owner[i]];
    endfunction

    function automatic logic [3:0] e_dat(int i);
        int s;
        s = m_in_g[i] ? m_owner[i] : 0;
        return data[s*4 +: 4];
    endfunction

    function automatic logic [11:0] e_ack(int i);
        return (e_vld(i) && out_ready) ? e_grant(i) : 12'h000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_in_g[i]  = 1'b0;
            m_owner[i] = 0;
            m_ptr[i]   = 0;
            m_beats[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_in_g[i]  = 1'b0;
                m_ptr[i]   = 0;
                m_beats[i] = 0;
            end else if (!m_in_g[i]) begin
                for (int k = 0; k < 12; k++) begin
                    int idx;
                    idx = (m_ptr[i] + k) % 12;
                    if (!m_in_g[i] && req[idx]) begin
                        m_in_g[i]  = 1'b1;
                        m_owner[i] = idx;
                        m_beats[i] = 0;
                    end
                end
            end else if (!req[m_owner[i]]) begin
                m_in_g[i] = 1'b0;
                m_ptr[i]  = (m_owner[i] + 1) % 12;
            end else if (out_ready) begin
                m_beats[i]++;
                if (m_beats[i] == maxb[i]) begin
                    m_in_g[i] = 1'b0;
                    m_ptr[i]  = (m_owner[i] + 1) % 12;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        model_reset();
        req       = 12'($urandom);
        data      = {16'($urandom), $urandom};
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_grant[i] !== 12'h000) begin failures++; $display("FAIL reset_grant inst%0d got=%h want=000", i, d_grant[i]); end
                checks++;
                if (d_sel[i] !== 4'h0) begin failures++; $display("FAIL reset_sel inst%0d got=%h want=0", i, d_sel[i]); end
                checks++;
                if (d_vld[i] !== 1'b0 || d_ack[i] !== 12'h000) begin failures++; $display("FAIL reset_vld_ack inst%0d vld=%b ack=%h want 0/000", i, d_vld[i], d_ack[i]); end
                checks++;
                if (d_dat[i] !== data[3:0]) begin failures++; $display("FAIL reset_data inst%0d got=%h want=%h", i, d_dat[i], data[3:0]); end
            end
            tick();
        end
        req = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int acks;
        do_reset();
        req       = 12'h004;
        out_ready = 1'b1;
        acks      = 0;
        for (int c = 0; c < 7; c++) begin
            data = {16'($urandom), $urandom};
            #2;
            if (c == 0 || c == 5) begin
                checks++;
                if (d_grant[0] !== 12'h000) begin failures++; $display("FAIL single_idle c%0d got=%h want=000", c, d_grant[0]); end
            end
            if (c == 1 || c == 6) begin
                checks++;
                if (d_grant[0] !== 12'h004 || d_sel[0] !== 4'd2) begin failures++; $display("FAIL single_grant c%0d grant=%h sel=%0d want 004/2", c, d_grant[0], d_sel[0]); end
            end
            if (c >= 1 && c <= 5 && d_ack[0] == 12'h004) acks++;
            checks++;
            if (d_ack[0] !== e_ack(0) || d_dat[0] !== e_dat(0)) begin failures++; $display("FAIL single_model c%0d ack=%h dat=%h want %h/%h", c, d_ack[0], d_dat[0], e_ack(0), e_dat(0)); end
            tick();
        end
        checks++;
        if (acks != 4) begin failures++; $display("FAIL single_ack_count got=%0d want=4", acks); end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq[$];
        do_reset();
        req       = 12'hFFF;
        out_ready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            data = {16'($urandom), $urandom};
            #2;
            checks++;
            if ((d_grant[1] != 12'h000) != (c % 2 == 1)) begin failures++; $display("FAIL rr_cadence c%0d grant=%h want_active=%0d", c, d_grant[1], c % 2); end
            if (d_grant[1] != 12'h000) seq.push_back(d_sel[1]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_grant[i] !== e_grant(i) || d_ack[i] !== e_ack(i)) begin failures++; $display("FAIL rr_model inst%0d c%0d grant=%h ack=%h want %h/%h", i, c, d_grant[i], d_ack[i], e_grant(i), e_ack(i)); end
            end
            tick();
        end
        checks++;
        if (seq.size() != 13) begin
            failures++; $display("FAIL rr_count got=%0d want=13", seq.size());
        end else begin
            for (int k = 0; k < 13; k++) begin
                checks++;
                if (seq[k] !== 4'(k % 12)) begin failures++; $display("FAIL rr_seq k%0d got=%0d want=%0d", k, seq[k], k % 12); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] word;
        do_reset();
        req       = 12'h020;
        out_ready = 1'b0;
        data      = {16'($urandom), $urandom};
        word      = data[23:20];
        tick();
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (d_vld[0] !== 1'b1 || d_dat[0] !== word || d_ack[0] !== 12'h000) begin failures++; $display("FAIL bp_hold c%0d vld=%b dat=%h ack=%h want 1/%h/000", c, d_vld[0], d_dat[0], d_ack[0], word); end
            tick();
        end
        out_ready = 1'b1;
        #2;
        checks++;
        if (d_ack[0] !== 12'h020) begin failures++; $display("FAIL bp_release got=%h want=020", d_ack[0]); end
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        req       = 12'h080;
        out_ready = 1'b1;
        data      = {16'($urandom), $urandom};
        tick();
        #2;
        checks++;
        if (d_ack[0] !== 12'h080) begin failures++; $display("FAIL abort_first_word got=%h want=080", d_ack[0]); end
        tick();
        req = 12'h008;
        #2;
        checks++;
        if (d_vld[0] !== 1'b0 || d_ack[0] !== 12'h000 || d_grant[0] !== 12'h080) begin failures++; $display("FAIL abort_cycle vld=%b ack=%h grant=%h want 0/000/080", d_vld[0], d_ack[0], d_grant[0]); end
        tick();
        #2;
        checks++;
        if (d_grant[0] !== 12'h000) begin failures++; $display("FAIL abort_idle got=%h want=000", d_grant[0]); end
        tick();
        #2;
        checks++;
        if (d_grant[0] !== 12'h008 || d_sel[0] !== 4'd3) begin failures++; $display("FAIL abort_next grant=%h sel=%0d want 008/3", d_grant[0], d_sel[0]); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req       = 12'h800;
        out_ready = 1'b1;
        data      = {16'($urandom), $urandom};
        tick();
        req = 12'h801;
        #2;
        checks++;
        if (d_sel[0] !== 4'd11) begin failures++; $display("FAIL wrap_sel11 got=%0d want=11", d_sel[0]); end
        repeat (4) tick();
        #2;
        checks++;
        if (d_grant[0] !== 12'h000) begin failures++; $display("FAIL wrap_idle got=%h want=000", d_grant[0]); end
        tick();
        #2;
        checks++;
        if (d_grant[0] !== 12'h001 || d_sel[0] !== 4'd0) begin failures++; $display("FAIL wrap_next grant=%h sel=%0d want 001/0", d_grant[0], d_sel[0]); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req       = 12'h010;
        out_ready = 1'b1;
        data      = {16'($urandom), $urandom};
        tick();
        #2;
        checks++;
        if (d_grant[0] !== 12'h010) begin failures++; $display("FAIL areset_pre got=%h want=010", d_grant[0]); end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (d_grant[0] !== 12'h000 || d_vld[0] !== 1'b0 || d_ack[0] !== 12'h000 || d_sel[0] !== 4'd0) begin failures++; $display("FAIL areset_drop grant=%h vld=%b ack=%h sel=%0d want 000/0/000/0", d_grant[0], d_vld[0], d_ack[0], d_sel[0]); end
        req = 12'h00C;
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if (d_grant[0] !== 12'h000) begin failures++; $display("FAIL areset_release got=%h want=000", d_grant[0]); end
        tick();
        #2;
        checks++;
        if (d_grant[0] !== 12'h004 || d_sel[0] !== 4'd2) begin failures++; $display("FAIL areset_regrant grant=%h sel=%0d want 004/2", d_grant[0], d_sel[0]); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        req = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 0) req = 12'($urandom) & 12'($urandom);
            data      = {16'($urandom), $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_grant[i] !== e_grant(i) || d_sel[i] !== e_sel(i)) begin failures++; $display("FAIL rand_grant inst%0d c%0d grant=%h sel=%0d want %h/%0d", i, c, d_grant[i], d_sel[i], e_grant(i), e_sel(i)); end
                checks++;
                if (d_vld[i] !== e_vld(i) || d_dat[i] !== e_dat(i)) begin failures++; $display("FAIL rand_data inst%0d c%0d vld=%b dat=%h want %b/%h", i, c, d_vld[i], d_dat[i], e_vld(i), e_dat(i)); end
                checks++;
                if (d_ack[i] !== e_ack(i)) begin failures++; $display("FAIL rand_ack inst%0d c%0d got=%h want=%h", i, c, d_ack[i], e_ack(i)); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
